rrf_allocator: RTL and testbench
================================

# rrf_allocator

In-order allocator for rename register file (RRF) tags, placed in the dispatch stage directly upstream of the architectural register file / rename table. Each cycle it hands out at most one RRF tag to the dispatching instruction and drives the rename table's set-busy port with that tag. Tags are reclaimed in program order as the ROB commits. Pointers, occupancy and flush rollback are tracked as a circular buffer.

## Interface
- RRF_SEL, 6, tag width
- RRF_NUM, 64, number of RRF entries (= 2^RRF_SEL)
- REG_SEL, 5, logical register index width
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- req_i  in  1  dispatching instruction needs a tag
- dst_we_i  in  1  instruction writes a logical destination
- dst_num_i  in  REG_SEL  logical destination index
- stall_i  in  1  downstream stall; blocks allocation
- alloc_ready_o  out  1  a free tag exists (not full)
- alloc_fire_o  out  1  tag allocated this cycle
- alloc_rrftag_o  out  RRF_SEL  tag granted (valid when alloc_fire_o)
- dst_en_setbusy_o  out  1  to rename table set-busy enable
- dst_num_setbusy_o  out  REG_SEL  to rename table destination index
- dst_rrftag_setbusy_o  out  RRF_SEL  to rename table tag
- com_en_i  in  1  ROB commits its oldest entry this cycle
- com_rrftag_o  out  RRF_SEL  tag of oldest live entry (commit pointer)
- flush_i  in  1  misprediction flush: discard all uncommitted tags
- free_count_o  out  RRF_SEL+1  number of free tags
- rrf_full_o  out  1  all RRF_NUM tags in use

## Operation
- State: alloc_ptr (RRF_SEL), com_ptr (RRF_SEL), used (RRF_SEL+1).
- alloc_fire = req_i & ~stall_i & ~rrf_full_o & ~flush_eff & ~reset.
- alloc_rrftag_o = alloc_ptr; on fire alloc_ptr <= alloc_ptr+1, wrapping mod RRF_NUM (natural RRF_SEL-bit overflow).
- dst_en_setbusy_o = alloc_fire & dst_we_i & (dst_num_i != 0). x0 still consumes a tag (ROB slot) but never sets busy. dst_num_setbusy_o = dst_num_i; dst_rrftag_setbusy_o = alloc_ptr. All three are combinational.
- com_fire = com_en_i & (used != 0). com_ptr <= com_ptr+1 with wrap. Commit while empty is ignored.
- used <= used + alloc_fire − com_fire. Simultaneous alloc and commit leaves used unchanged and advances both pointers.
- rrf_full_o = (used == RRF_NUM). alloc_ready_o = ~rrf_full_o & ~reset. free_count_o = RRF_NUM − used.
- Full is evaluated on current-cycle state: a commit in the same cycle does not unblock allocation until the next cycle.
- Flush (flush_eff = flush_i, see Configuration):
  - alloc_ptr <= com_ptr + com_fire.
  - used <= 0.
  - Allocation is suppressed that cycle.
  - A commit in the same cycle is honored before rollback.
- Reset: alloc_ptr = com_ptr = 0, used = 0. While reset is high, all fire/enable outputs are 0. After reset: alloc_ready_o=1, free_count_o=64, rrf_full_o=0, com_rrftag_o=0, alloc_rrftag_o=0.

## Timing
- Allocation is zero-latency. Tag and set-busy signals are valid in the same cycle as req_i, and the rename table captures them at the same edge at which alloc_ptr advances.
- Back-to-back allocation runs at one tag per cycle. Successive tags are consecutive mod RRF_NUM (63 → 0).
- Commit takes effect on the next edge; com_rrftag_o updates one cycle after com_en_i.
- Flush takes effect on the next edge. The first post-flush tag equals the post-flush com_rrftag_o.
- No combinational path from com_en_i to alloc_ready_o.
- Reset asserted mid-stream clears all state at the next edge regardless of other inputs.

## Configuration
- RRF_ALLOC_FLUSH_EN defined: flush_i behaves as above.
- RRF_ALLOC_FLUSH_EN undefined: flush_eff is tied to 0, flush_i is ignored, and the rollback logic is not synthesized. The port is kept so the interface does not change.

## Test plan
- Reset, then req_i=1, dst_we_i=1, dst_num_i=5 for 3 cycles -> tags 0,1,2; setbusy enable=1 with num=5 each cycle; free_count_o=61.
- 64 consecutive allocations with no commit -> rrf_full_o=1, alloc_ready_o=0. A 65th request with com_en_i=1 in the same cycle -> no fire that cycle; fire next cycle with tag 0.
- Allocate 64 and commit 64 in lockstep, then 2 more allocations -> tags wrap 62,63,0,1; com_rrftag_o follows with a one-cycle lag; used stays ≤1.
- dst_num_i=0 with dst_we_i=1 -> alloc_fire_o=1, tag consumed, dst_en_setbusy_o=0.
- With RRF_ALLOC_FLUSH_EN: allocate tags 0–9, commit 3, then flush_i together with com_en_i -> next cycle used=0, free_count_o=64, next tag=4. Without the macro, the same stimulus gives used=6 and next tag=10.
- Assert reset while used=20 and req_i=1 -> alloc_fire_o=0 during reset; next cycle tag=0, free_count_o=64; com_en_i on empty -> no change.

Source files
------------

// File: rtl/rrf_allocator.sv
`default_nettype none
// ============================================================================
// Module      : rrf_allocator
// Description : In-order allocator for rename register file (RRF) tags.
//               Hands out at most one tag per cycle to the dispatching
//               instruction and drives the rename table set-busy port with
//               it. Tags are reclaimed in program order as the ROB commits.
//               The RRF is managed as a circular buffer: alloc pointer,
//               commit pointer and an explicit occupancy count.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk                  in   clock, all state updates on rising edge
//   reset                in   synchronous active-high reset
//   req_i                in   dispatching instruction needs a tag
//   dst_we_i             in   instruction writes a logical destination
//   dst_num_i            in   logical destination index
//   stall_i              in   downstream stall, blocks allocation
//   alloc_ready_o        out  a free tag exists
//   alloc_fire_o         out  tag allocated this cycle
//   alloc_rrftag_o       out  tag granted (valid with alloc_fire_o)
//   dst_en_setbusy_o     out  rename table set-busy enable
//   dst_num_setbusy_o    out  rename table destination index
//   dst_rrftag_setbusy_o out  rename table tag
//   com_en_i             in   ROB commits its oldest entry this cycle
//   com_rrftag_o         out  tag of oldest live entry
//   flush_i              in   misprediction flush (see RRF_ALLOC_FLUSH_EN)
//   free_count_o         out  number of free tags
//   rrf_full_o           out  all tags in use
// ----------------------------------------------------------------------------
// Build option
//   RRF_ALLOC_FLUSH_EN : when defined, flush_i rolls the alloc pointer back
//                        to the commit pointer and empties the buffer. When
//                        undefined, flush_i is ignored and no rollback logic
//                        is built; the port remains for interface stability.
// ============================================================================
module rrf_allocator #(
    parameter int RRF_SEL = 6,
    parameter int RRF_NUM = 64,
    parameter int REG_SEL = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req_i,
    input  logic               dst_we_i,
    input  logic [REG_SEL-1:0] dst_num_i,
    input  logic               stall_i,
    output logic               alloc_ready_o,
    output logic               alloc_fire_o,
    output logic [RRF_SEL-1:0] alloc_rrftag_o,
    output logic               dst_en_setbusy_o,
    output logic [REG_SEL-1:0] dst_num_setbusy_o,
    output logic [RRF_SEL-1:0] dst_rrftag_setbusy_o,
    input  logic               com_en_i,
    output logic [RRF_SEL-1:0] com_rrftag_o,
    input  logic               flush_i,
    output logic [RRF_SEL:0]   free_count_o,
    output logic               rrf_full_o
);

    localparam logic [RRF_SEL:0]   c_rrf_num  = (RRF_SEL+1)'(RRF_NUM);
    localparam logic [RRF_SEL-1:0] c_tag_one  = RRF_SEL'(1);

    logic [RRF_SEL-1:0] r_alloc_ptr;
    logic [RRF_SEL-1:0] r_com_ptr;
    logic [RRF_SEL:0]   r_used;

    logic               w_full;
    logic               w_flush_eff;
    logic               w_alloc_fire;
    logic               w_com_fire;
    logic [RRF_SEL-1:0] w_alloc_ptr_nxt;
    logic [RRF_SEL-1:0] w_com_ptr_nxt;
    logic [RRF_SEL:0]   w_used_nxt;

`ifdef RRF_ALLOC_FLUSH_EN
    assign w_flush_eff = flush_i;
`else
    // Port kept for interface compatibility; its value has no effect.
    logic w_flush_unused;
    assign w_flush_unused = flush_i;
    assign w_flush_eff    = 1'b0;
`endif

    // Full is judged on the registered occupancy only, so a same-cycle
    // commit cannot open a combinational path from com_en_i to allocation.
    assign w_full       = (r_used == c_rrf_num);
    assign w_alloc_fire = req_i & ~stall_i & ~w_full & ~w_flush_eff & ~reset;
    // Commit on an empty buffer is dropped so the pointers never cross.
    assign w_com_fire   = com_en_i & (r_used != '0);

    assign w_com_ptr_nxt = w_com_fire ? (r_com_ptr + c_tag_one) : r_com_ptr;

`ifdef RRF_ALLOC_FLUSH_EN
    // Rollback: the commit of this cycle is honoured first, then every
    // remaining uncommitted tag is discarded.
    always_comb begin
        if (w_flush_eff) begin
            w_alloc_ptr_nxt = w_com_ptr_nxt;
            w_used_nxt      = '0;
        end else begin
            w_alloc_ptr_nxt = w_alloc_fire ? (r_alloc_ptr + c_tag_one) : r_alloc_ptr;
            w_used_nxt      = r_used + (RRF_SEL+1)'(w_alloc_fire)
                                     - (RRF_SEL+1)'(w_com_fire);
        end
    end
`else
    assign w_alloc_ptr_nxt = w_alloc_fire ? (r_alloc_ptr + c_tag_one) : r_alloc_ptr;
    assign w_used_nxt      = r_used + (RRF_SEL+1)'(w_alloc_fire)
                                    - (RRF_SEL+1)'(w_com_fire);
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_alloc_ptr <= '0;
            r_com_ptr   <= '0;
            r_used      <= '0;
        end else begin
            r_alloc_ptr <= w_alloc_ptr_nxt;
            r_com_ptr   <= w_com_ptr_nxt;
            r_used      <= w_used_nxt;
        end
    end

    assign alloc_ready_o        = ~w_full & ~reset;
    assign alloc_fire_o         = w_alloc_fire;
    assign alloc_rrftag_o       = r_alloc_ptr;
    // Logical register 0 still consumes a tag but never marks busy.
    assign dst_en_setbusy_o     = w_alloc_fire & dst_we_i & (dst_num_i != '0);
    assign dst_num_setbusy_o    = dst_num_i;
    assign dst_rrftag_setbusy_o = r_alloc_ptr;
    assign com_rrftag_o         = r_com_ptr;
    assign free_count_o         = c_rrf_num - r_used;
    assign rrf_full_o           = w_full;

endmodule
`default_nettype wire

// File: tb/tb_rrf_allocator.sv
`default_nettype none
// ============================================================================
// Module      : tb_rrf_allocator
// Description : Self-checking bench for rrf_allocator. A queue of live tags
//               plus a next-tag counter forms the reference model; directed
//               scenarios are followed by a randomized run.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rrf_allocator;

`ifdef RRF_ALLOC_FLUSH_EN
    localparam bit FLUSH_EN = 1'b1;
`else
    localparam bit FLUSH_EN = 1'b0;
`endif

    logic       clk;
    logic       reset;
    logic       req_i;
    logic       dst_we_i;
    logic [4:0] dst_num_i;
    logic       stall_i;
    logic       alloc_ready_o;
    logic       alloc_fire_o;
    logic [5:0] alloc_rrftag_o;
    logic       dst_en_setbusy_o;
    logic [4:0] dst_num_setbusy_o;
    logic [5:0] dst_rrftag_setbusy_o;
    logic       com_en_i;
    logic [5:0] com_rrftag_o;
    logic       flush_i;
    logic [6:0] free_count_o;
    logic       rrf_full_o;

    rrf_allocator #(.RRF_SEL(6), .RRF_NUM(64), .REG_SEL(5)) dut (
        .clk                  (clk),
        .reset                (reset),
        .req_i                (req_i),
        .dst_we_i             (dst_we_i),
        .dst_num_i            (dst_num_i),
        .stall_i              (stall_i),
        .alloc_ready_o        (alloc_ready_o),
        .alloc_fire_o         (alloc_fire_o),
        .alloc_rrftag_o       (alloc_rrftag_o),
        .dst_en_setbusy_o     (dst_en_setbusy_o),
        .dst_num_setbusy_o    (dst_num_setbusy_o),
        .dst_rrftag_setbusy_o (dst_rrftag_setbusy_o),
        .com_en_i             (com_en_i),
        .com_rrftag_o         (com_rrftag_o),
        .flush_i              (flush_i),
        .free_count_o         (free_count_o),
        .rrf_full_o           (rrf_full_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: tags currently live, in program order, and the tag
    // the next allocation will receive.
    int live_q[$];
    int next_tag = 0;
    bit exp_fire;
    bit exp_com;
    bit exp_flush;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int model_com_tag();
        return (live_q.size() != 0) ? live_q[0] : next_tag;
    endfunction

    // Apply inputs, then compare every output against the model at the
    // falling edge.
    task automatic drive(input bit r, input bit we, input int n, input bit st,
                         input bit cm, input bit fl, input bit rs);
        bit full;
        req_i = r; dst_we_i = we; dst_num_i = 5'(n); stall_i = st;
        com_en_i = cm; flush_i = fl; reset = rs;
        @(negedge clk);
        full      = (live_q.size() == 64);
        exp_flush = FLUSH_EN && fl;
        exp_fire  = r && !st && !full && !exp_flush && !rs;
        exp_com   = cm && (live_q.size() != 0);
        chk("alloc_fire", alloc_fire_o, exp_fire);
        chk("alloc_ready", alloc_ready_o, !full && !rs);
        chk("rrf_full", rrf_full_o, full);
        chk("free_count", free_count_o, 64 - live_q.size());
        chk("com_rrftag", com_rrftag_o, model_com_tag());
        chk("dst_en_setbusy", dst_en_setbusy_o, exp_fire && we && (n != 0));
        chk("dst_num_setbusy", dst_num_setbusy_o, n);
        chk("dst_rrftag_setbusy", dst_rrftag_setbusy_o, next_tag);
        if (exp_fire) chk("alloc_rrftag", alloc_rrftag_o, next_tag);
    endtask

    task automatic tick();
        int keep;
        @(posedge clk);
        if (reset) begin
            live_q.delete();
            next_tag = 0;
        end else begin
            if (exp_com) void'(live_q.pop_front());
            if (exp_flush) begin
                keep = model_com_tag();
                live_q.delete();
                next_tag = keep;
            end else if (exp_fire) begin
                live_q.push_back(next_tag);
                next_tag = (next_tag + 1) % 64;
            end
        end
        #1;
    endtask

    task automatic step(input bit r, input bit we, input int n, input bit st,
                        input bit cm, input bit fl, input bit rs);
        drive(r, we, n, st, cm, fl, rs);
        tick();
    endtask

    task automatic do_reset();
        step(0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 1);
    endtask

    initial begin
        reset = 1'b1; req_i = 0; dst_we_i = 0; dst_num_i = 0;
        stall_i = 0; com_en_i = 0; flush_i = 0;

        // Reset state
        do_reset();
        drive(0, 0, 0, 0, 0, 0, 0);
        chk("rst_ready", alloc_ready_o, 1);
        chk("rst_free", free_count_o, 64);
        chk("rst_full", rrf_full_o, 0);
        chk("rst_comtag", com_rrftag_o, 0);
        chk("rst_tag", alloc_rrftag_o, 0);
        tick();

        // Three allocations to r5
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 5, 0, 0, 0, 0);
            chk("t1_tag", alloc_rrftag_o, i);
            chk("t1_setbusy", dst_en_setbusy_o, 1);
            tick();
        end
        drive(0, 0, 0, 0, 0, 0, 0);
        chk("t1_free", free_count_o, 61);
        tick();

        // Fill completely, then a request with a same-cycle commit
        do_reset();
        for (int i = 0; i < 64; i++) step(1, 1, (i % 31) + 1, 0, 0, 0, 0);
        drive(1, 1, 3, 0, 1, 0, 0);
        chk("full_flag", rrf_full_o, 1);
        chk("full_ready", alloc_ready_o, 0);
        chk("full_nofire", alloc_fire_o, 0);
        tick();
        drive(1, 1, 3, 0, 0, 0, 0);
        chk("after_full_fire", alloc_fire_o, 1);
        chk("after_full_tag", alloc_rrftag_o, 0);
        tick();

        // Lockstep allocate/commit across the wrap point
        do_reset();
        for (int i = 0; i < 66; i++) begin
            drive(1, 1, 7, 0, 1, 0, 0);
            chk("lock_tag", alloc_rrftag_o, i % 64);
            chk("lock_used", (free_count_o >= 7'd63), 1);
            tick();
        end
        drive(0, 0, 0, 0, 0, 0, 0);
        chk("lock_comtag", com_rrftag_o, 1);
        tick();

        // x0 destination consumes a tag without set-busy
        drive(1, 1, 0, 0, 0, 0, 0);
        chk("x0_fire", alloc_fire_o, 1);
        chk("x0_setbusy", dst_en_setbusy_o, 0);
        tick();

        // Flush with same-cycle commit
        do_reset();
        for (int i = 0; i < 10; i++) step(1, 1, 9, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++)  step(0, 0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 1, 1, 0);
        drive(1, 1, 9, 0, 0, 0, 0);
        chk("flush_free", free_count_o, FLUSH_EN ? 64 : 58);
        chk("flush_tag", alloc_rrftag_o, FLUSH_EN ? 4 : 10);
        chk("flush_comtag", com_rrftag_o, 4);
        tick();

        // Reset mid-stream
        do_reset();
        for (int i = 0; i < 20; i++) step(1, 1, 2, 0, 0, 0, 0);
        drive(1, 1, 2, 0, 0, 0, 1);
        chk("midrst_nofire", alloc_fire_o, 0);
        chk("midrst_nosetbusy", dst_en_setbusy_o, 0);
        tick();
        drive(0, 0, 0, 0, 1, 0, 0);
        chk("midrst_tag", alloc_rrftag_o, 0);
        chk("midrst_free", free_count_o, 64);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        chk("empty_com_tag", com_rrftag_o, 0);
        chk("empty_com_free", free_count_o, 64);
        tick();

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            step($urandom_range(99) < 70, $urandom_range(1), $urandom_range(31),
                 $urandom_range(99) < 15, $urandom_range(99) < 40,
                 $urandom_range(99) < 3,  $urandom_range(199) < 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
